// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler: deals nonces from a range to a bank of SHA-256 units and reports the first result below target
module sha256_nonce_scheduler #(
  parameter int NUM_UNITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [31:0]             nonce_base_i,
  input  logic [31:0]             nonce_count_i,
  input  logic [31:0]             target_i,
  output logic [NUM_UNITS-1:0]    unit_start_o,
  output logic [NUM_UNITS*32-1:0] unit_nonce_o,
  input  logic [NUM_UNITS-1:0]    unit_done_i,
  input  logic [NUM_UNITS*32-1:0] unit_result_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    found_o,
  output logic [31:0]             found_nonce_o,
  output logic [31:0]             hashes_done_o
);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_e;
  state_e state_q, state_d;
  logic [31:0] next_nonce_q, next_nonce_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] found_nonce_q, found_nonce_d;
  logic [31:0] hashes_q, hashes_d;
  logic found_q, found_d;
  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic [31:0] nonce_q [NUM_UNITS];
  logic [31:0] nonce_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] completed, winners, win_oh, free, dispatch_oh;
  logic [31:0] win_nonce;
  logic [32:0] hash_sum;
  logic accept, checking, win, dispatch_en;

  assign accept = (state_q == IDLE) && start_i;

  // Completions from busy units only; lowest-index winner takes the search
  always_comb begin
    completed = unit_done_i & busy_q;
    for (int i = 0; i < NUM_UNITS; i++) winners[i] = completed[i] && (unit_result_i[i*32 +: 32] < tgt_q);
    checking = (state_q == DISPATCH) && !found_q && !abort_i;
    win_oh = winners & (~winners + NUM_UNITS'(1));
    win = checking && |winners;
    win_nonce = '0;
    for (int i = 0; i < NUM_UNITS; i++) win_nonce = win_nonce | (win_oh[i] ? nonce_q[i] : 32'd0);
    hash_sum = {1'b0, hashes_q};
    for (int i = 0; i < NUM_UNITS; i++) hash_sum = hash_sum + 33'(completed[i]);
  end

  // One dispatch per cycle to the lowest-index free unit, suppressed on win or abort
  always_comb begin
    free = ~busy_q;
    dispatch_en = (state_q == DISPATCH) && (remaining_q != 32'd0) && |free && !win && !abort_i;
    dispatch_oh = dispatch_en ? (free & (~free + NUM_UNITS'(1))) : '0;
  end

  // Datapath next state; an accepted start reloads the search parameters
  always_comb begin
    next_nonce_d = dispatch_en ? next_nonce_q + 32'd1 : next_nonce_q;
    remaining_d = dispatch_en ? remaining_q - 32'd1 : remaining_q;
    tgt_d = tgt_q;
    found_d = found_q | win;
    found_nonce_d = win ? win_nonce : found_nonce_q;
    hashes_d = hash_sum[32] ? 32'hFFFF_FFFF : hash_sum[31:0];
    busy_d = (busy_q & ~completed) | dispatch_oh;
    start_d = dispatch_oh;
    for (int i = 0; i < NUM_UNITS; i++) nonce_d[i] = dispatch_oh[i] ? next_nonce_q : nonce_q[i];
    if (accept) begin
      next_nonce_d = nonce_base_i;
      remaining_d = nonce_count_i;
      tgt_d = target_i;
      found_d = 1'b0;
      found_nonce_d = '0;
      hashes_d = '0;
    end
  end

  // Search sequencing: dispatch until win/abort/exhausted, drain in-flight jobs, pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start_i ? DISPATCH : IDLE;
      DISPATCH: state_d = (win || abort_i || remaining_d == 32'd0) ? DRAIN : DISPATCH;
      DRAIN:    state_d = (busy_q == '0) ? FINISH : DRAIN;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs straight from state and registers
  always_comb begin
    busy_o = state_q != IDLE;
    done_o = state_q == FINISH;
    unit_start_o = start_q;
    found_o = found_q;
    found_nonce_o = found_nonce_q;
    hashes_done_o = hashes_q;
    for (int i = 0; i < NUM_UNITS; i++) unit_nonce_o[i*32 +: 32] = nonce_q[i];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Datapath registers; reset drops every busy flag so late completions are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_nonce_q <= '0;
      remaining_q <= '0;
      tgt_q <= '0;
      found_q <= 1'b0;
      found_nonce_q <= '0;
      hashes_q <= '0;
      busy_q <= '0;
      start_q <= '0;
      nonce_q <= '{default: '0};
    end else begin
      next_nonce_q <= next_nonce_d;
      remaining_q <= remaining_d;
      tgt_q <= tgt_d;
      found_q <= found_d;
      found_nonce_q <= found_nonce_d;
      hashes_q <= hashes_d;
      busy_q <= busy_d;
      start_q <= start_d;
      nonce_q <= nonce_d;
    end
  end
endmodule

// File: doc/sha256_nonce_scheduler.md
# sha256_nonce_scheduler

Job scheduler that shares a search range of nonces across NUM_UNITS parallel SHA-256 double-hash units. It dispatches one nonce per free unit and collects each 32-bit result word. It compares every result against a target and reports the first winning nonce. It sits between the host/control registers and the bank of SHA-256 units; the message-template assembly that inserts `unit_nonce` into each unit's block lives outside this block.

## Interface
- NUM_UNITS, 4: number of SHA-256 units served (1..16).
- clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  stop dispatching and drain; sampled in DISPATCH only.
- nonce_base  in  32  first nonce of the range; latched on accepted start.
- nonce_count  in  32  number of nonces to try; latched on accepted start.
- target  in  32  win threshold; latched on accepted start.
- unit_start  out  NUM_UNITS  one-cycle pulse per dispatched job, per unit.
- unit_nonce  out  NUM_UNITS×32  nonce assigned to each unit; held stable until that unit's next dispatch.
- unit_done  in  NUM_UNITS  one-cycle completion pulse per unit.
- unit_result  in  NUM_UNITS×32  result word, valid in the unit_done cycle.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at end of search.
- found  out  1  a winner was seen in this search; held until the next accepted start.
- found_nonce  out  32  winning nonce; held until the next accepted start.
- hashes_done  out  32  completed jobs this search, saturating at 0xFFFFFFFF.

## Operation
- Reset values: state IDLE; all outputs 0; all unit busy flags cleared.
- States: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE + start:
  - latch base, count and target into next_nonce, remaining and tgt;
  - clear found, found_nonce and hashes_done;
  - go to DISPATCH.
- DISPATCH, each cycle with remaining > 0 and at least one unit not busy:
  - select the lowest-index non-busy unit k;
  - register unit_start[k]=1 and unit_nonce[k]=next_nonce;
  - set busy[k];
  - next_nonce+1 (mod 2^32, wraps 0xFFFFFFFF→0); remaining−1.
- At most one dispatch per cycle.
- Busy flags are registered. A unit whose unit_done arrives in cycle t is dispatchable from cycle t+1, not t.
- Completion: unit_done[k] with busy[k]=1 clears busy[k] and increments hashes_done. unit_done[k] with busy[k]=0 is ignored entirely.
- Win check: result < tgt (unsigned), applied only in DISPATCH and only when found=0.
  - On a win, set found=1 and found_nonce=unit_nonce[k].
  - If several units win in the same cycle, the lowest index wins.
- DISPATCH → DRAIN when any of:
  - a win is recorded;
  - abort=1;
  - remaining reaches 0.
- Abort priority: results in the abort cycle still count toward hashes_done but are not win-checked.
- DRAIN:
  - no dispatch;
  - completions still count toward hashes_done;
  - results are not win-checked.
  - When all busy flags are clear, go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- nonce_count=0: DISPATCH → DRAIN → FINISH with no dispatch; found=0.
- start outside IDLE is ignored. abort outside DISPATCH is ignored.
- Asynchronous reset mid-search returns to IDLE immediately and drops all busy flags. Late unit_done pulses are then ignored.

## Timing
- start sampled at edge E0 → busy=1 after E0.
  - unit_start[0]=1 with unit_nonce[0]=nonce_base after E1.
  - Units 1..NUM_UNITS−1 follow after E2..E_NUM_UNITS, given enough nonces.
- unit_start is high for exactly one cycle per dispatch; unit_nonce is valid in that cycle and afterwards.
- Win latency: unit_done at edge Ew → found/found_nonce updated after Ew; no unit_start after Ew.
- Done latency: the last busy flag clears at edge Ex → FINISH after Ex+1, so done is high during cycle Ex+1..Ex+2. busy falls after Ex+2.
- Minimum search (nonce_count=0): done high in the 3rd cycle after start.

## Test plan
- Reset check: hold reset_n=0, pulse clk → busy, done, found, unit_start, hashes_done all 0; state IDLE.
- No winner:
  - stimulus: NUM_UNITS=4, base=0x100, count=6, target=0; units reply after 70 cycles with result 0xFFFFFFFF;
  - response: dispatch order units 0,1,2,3 with nonces 0x100..0x103; then 0x104 and 0x105 on the first two freed units; done once; found=0; hashes_done=6.
- Winner mid-range:
  - stimulus: base=0, count=100, target=0x00001000; the unit holding nonce 5 returns 0x00000FFF;
  - response: found=1, found_nonce=5; no further unit_start; drains in-flight jobs; done once.
- Simultaneous winners: units 2 and 1 both return results below target in the same cycle → found_nonce equals unit 1's nonce.
- Wrap and abort:
  - base=0xFFFFFFFE, count=4 → nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1;
  - abort asserted after the 2nd dispatch → exactly 2 jobs issued, then done, found=0.
- Edge cases:
  - count=0 → done in the 3rd cycle after start, no unit_start;
  - start while busy → ignored;
  - stray unit_done on an idle unit → hashes_done unchanged;
  - reset_n asserted mid-DRAIN → IDLE immediately.
